// File: rtl/voice_level_display_pkg.sv
// voice_level_display_pkg: seven-segment constants and window FSM states shared by the level display
package voice_level_display_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF = 4'hF;
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef enum logic {ACCUM, LATCH} win_state_t;
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        return SEG_HEX[n];
    endfunction
endpackage

// File: rtl/voice_level_display_seg7_scan_mux.sv
// seg7_scan_mux: scans a 16-bit hex word onto four active-low multiplexed 7-segment digits
module seg7_scan_mux
    import voice_level_display_pkg::*;
#(
    parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic [15:0] hex,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    logic [15:0] cnt;
    logic [1:0]  idx;
    logic        wrap;
    assign wrap = cnt == REFRESH_DIV - 16'd1;
    // anode, segments and dp all derive from the same idx so they switch on one edge
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            cnt <= '0;
            idx <= '0;
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            cnt <= wrap ? '0 : cnt + 16'd1;
            idx <= wrap ? idx + 2'd1 : idx;
            an  <= ~(4'b0001 << idx);
            seg <= hex_to_seg(hex[{idx, 2'b00} +: 4]);
            dp  <= ~dp_mask[idx];
        end
    end
endmodule

// File: rtl/voice_level_display.sv
// voice_level_display: windowed mean-abs level, peak hold and voice-activity flag shown on a 4-digit display
module voice_level_display
    import voice_level_display_pkg::*;
#(
    parameter int          WIN_LOG2    = 4,
    parameter logic [7:0]  THRESH      = 8'd16,
    parameter int          HANG        = 3,
    parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic [7:0] level,
    output logic [7:0] peak,
    input  logic       peak_clr,
    output logic       window_done,
    output logic       voice_active,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int AW = 9 + WIN_LOG2;
    localparam logic [WIN_LOG2:0] WIN_LEN = (WIN_LOG2 + 1)'(1) << WIN_LOG2;
    win_state_t        state, state_nxt;
    logic [AW-1:0]     acc, acc_nxt, base_acc, sum;
    logic [WIN_LOG2:0] cnt, cnt_nxt, base_cnt, cnt1;
    logic [8:0]        mag;
    logic [7:0]        level_nxt, peak_nxt, peak_base, lvl_new, hang, hang_nxt;
    logic              done, loud, wd_nxt, va_nxt;
    assign mag = sample_in[7] ? ~{1'b1, sample_in} + 9'd1 : {1'b0, sample_in};
    // LATCH starts a fresh window, so a sample arriving there becomes the first of the next one;
    // the level is computed on the edge that captures the final sample so it is visible during LATCH
    always_comb begin
        base_acc  = state == LATCH ? '0 : acc;
        base_cnt  = state == LATCH ? '0 : cnt;
        sum       = base_acc + AW'(mag);
        cnt1      = base_cnt + (WIN_LOG2 + 1)'(1);
        done      = sample_valid && cnt1 == WIN_LEN;
        lvl_new   = 8'(sum >> WIN_LOG2);
        loud      = lvl_new >= THRESH;
        state_nxt = done ? LATCH : ACCUM;
        acc_nxt   = sample_valid ? sum : base_acc;
        cnt_nxt   = sample_valid ? cnt1 : base_cnt;
        level_nxt = done ? lvl_new : level;
        wd_nxt    = done;
        hang_nxt  = !done ? hang : loud ? 8'(HANG) : hang != 8'd0 ? hang - 8'd1 : hang;
        va_nxt    = !done ? voice_active : loud ? 1'b1 : hang != 8'd0 ? voice_active : 1'b0;
        peak_base = peak_clr ? '0 : peak;
        peak_nxt  = sample_valid && mag > {1'b0, peak_base} ? mag[7:0] : peak_base;
    end
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state        <= ACCUM;
            acc          <= '0;
            cnt          <= '0;
            level        <= '0;
            peak         <= '0;
            hang         <= '0;
            window_done  <= 1'b0;
            voice_active <= 1'b0;
        end else begin
            state        <= state_nxt;
            acc          <= acc_nxt;
            cnt          <= cnt_nxt;
            level        <= level_nxt;
            peak         <= peak_nxt;
            hang         <= hang_nxt;
            window_done  <= wd_nxt;
            voice_active <= va_nxt;
        end
    end
    seg7_scan_mux #(.REFRESH_DIV(REFRESH_DIV)) u_scan (
        .clk     (clk),
        .nRESET  (nRESET),
        .hex     ({peak, level}),
        .dp_mask ({3'b000, voice_active}),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );
endmodule
